// File: rtl/gsim_bmat.sv
// gsim_bmat: forward banded matrix-vector multiplier b = A*x.
// A is the fixed 16x16 band matrix with diagonal 20, +-1 -> -13,
// +-2 -> +6, +-3 -> -1. x arrives as 16 serial Q16.16 words.
// Once the 16th word is captured, the block emits one row of b per cycle.
// Each row is given as full-precision Q22.16 (b_full) and as a
// rounded/saturated int16 (b_out).
module gsim_bmat #(
    parameter bit ROUND_EN = 1'b1,
    parameter bit SAT_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_en,
    input  logic [31:0] x_in,
    output logic        out_valid,
    output logic [15:0] b_out,
    output logic [37:0] b_full,
    output logic        busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CALC = 1'b1
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [3:0]  r_row;
    logic [31:0] r_buf [16];
    logic        r_valid;
    logic [15:0] r_b_out;
    logic [37:0] r_b_full;
    logic        r_busy;

    // Band taps around the current row; taps outside 0..15 read as zero.
    logic [31:0] w_xc;
    logic [31:0] w_xm1;
    logic [31:0] w_xp1;
    logic [31:0] w_xm2;
    logic [31:0] w_xp2;
    logic [31:0] w_xm3;
    logic [31:0] w_xp3;

    assign w_xc  = r_buf[r_row];
    assign w_xm1 = (r_row >= 4'd1)  ? r_buf[r_row - 4'd1] : 32'd0;
    assign w_xp1 = (r_row <= 4'd14) ? r_buf[r_row + 4'd1] : 32'd0;
    assign w_xm2 = (r_row >= 4'd2)  ? r_buf[r_row - 4'd2] : 32'd0;
    assign w_xp2 = (r_row <= 4'd13) ? r_buf[r_row + 4'd2] : 32'd0;
    assign w_xm3 = (r_row >= 4'd3)  ? r_buf[r_row - 4'd3] : 32'd0;
    assign w_xp3 = (r_row <= 4'd12) ? r_buf[r_row + 4'd3] : 32'd0;

    // Sign-extend every tap to the 38-bit accumulator width.
    function automatic logic signed [37:0] sext38(input logic [31:0] v);
        sext38 = {{6{v[31]}}, v};
    endfunction

    logic signed [37:0] w_c;
    logic signed [37:0] w_p1;
    logic signed [37:0] w_p2;
    logic signed [37:0] w_p3;
    logic signed [37:0] w_t20;
    logic signed [37:0] w_t13;
    logic signed [37:0] w_t6;
    logic signed [37:0] w_sum;
    logic signed [37:0] w_rnd;
    logic signed [21:0] w_int;
    logic        [15:0] w_b_out;

    assign w_c  = sext38(w_xc);
    assign w_p1 = sext38(w_xm1) + sext38(w_xp1);
    assign w_p2 = sext38(w_xm2) + sext38(w_xp2);
    assign w_p3 = sext38(w_xm3) + sext38(w_xp3);

    // Constant coefficients as shift-add: 20 = 16+4, 13 = 8+4+1, 6 = 4+2.
    assign w_t20 = (w_c <<< 4) + (w_c <<< 2);
    assign w_t13 = (w_p1 <<< 3) + (w_p1 <<< 2) + w_p1;
    assign w_t6  = (w_p2 <<< 2) + (w_p2 <<< 1);
    assign w_sum = w_t20 - w_t13 + w_t6 - w_p3;

    // Round half toward +inf by biasing before the floor shift.
    assign w_rnd = ROUND_EN ? (w_sum + 38'sd32768) : w_sum;
    assign w_int = w_rnd[37:16];

    // Integer conversion: either clamp to int16 or keep the low 16 bits.
    always_comb begin
        w_b_out = w_int[15:0];
        if (SAT_EN) begin
            if (w_int > 22'sd32767) begin
                w_b_out = 16'h7FFF;
            end else if (w_int < -22'sd32768) begin
                w_b_out = 16'h8000;
            end else begin
                w_b_out = w_int[15:0];
            end
        end else begin
            w_b_out = w_int[15:0];
        end
    end

    // Control FSM, x buffer capture and registered row outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_row    <= 4'd0;
            r_valid  <= 1'b0;
            r_b_out  <= 16'd0;
            r_b_full <= 38'd0;
            r_busy   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_buf[i] <= 32'd0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    if (in_en) begin
                        r_buf[r_cnt] <= x_in;
                        if (r_cnt == 4'd15) begin
                            r_cnt   <= 4'd0;
                            r_row   <= 4'd0;
                            r_state <= S_CALC;
                            r_busy  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                S_CALC: begin
                    // in_en is deliberately ignored here.
                    r_valid  <= 1'b1;
                    r_b_out  <= w_b_out;
                    r_b_full <= w_sum;
                    if (r_row == 4'd15) begin
                        r_row   <= 4'd0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_row <= r_row + 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_valid;
    assign b_out     = r_b_out;
    assign b_full    = r_b_full;
    assign busy      = r_busy;

endmodule

// File: tb/tb_gsim_bmat.sv
// Self-checking bench for gsim_bmat. Two instances share the stimulus:
// one rounds and saturates, the other truncates and wraps. The reference
// model computes each b row as a dot product with the band matrix,
// using coefficients looked up by distance from the diagonal.
module tb_gsim_bmat;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_en = 1'b0;
    logic [31:0] x_in = 32'd0;

    logic        rs_valid, tw_valid;
    logic [15:0] rs_b_out, tw_b_out;
    logic [37:0] rs_b_full, tw_b_full;
    logic        rs_busy, tw_busy;

    gsim_bmat #(.ROUND_EN(1'b1), .SAT_EN(1'b1)) dut_rs (
        .clk(clk), .reset(reset), .in_en(in_en), .x_in(x_in),
        .out_valid(rs_valid), .b_out(rs_b_out), .b_full(rs_b_full), .busy(rs_busy)
    );

    gsim_bmat #(.ROUND_EN(1'b0), .SAT_EN(1'b0)) dut_tw (
        .clk(clk), .reset(reset), .in_en(in_en), .x_in(x_in),
        .out_valid(tw_valid), .b_out(tw_b_out), .b_full(tw_b_full), .busy(tw_busy)
    );

    always #5 clk = ~clk;

    // Count rising edges; at a falling edge cyc equals the number of edges seen.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        longint full;
        longint rs;
        longint tw;
        int     at;
    } exp_t;

    exp_t   q[$];
    int     m_buf [16];
    int     m_cnt = 0;
    int     m_e0 = -1000;
    longint last_full = 0;
    longint last_rs = 0;
    longint last_tw = 0;

    function automatic longint ref_sum(input int r);
        longint s;
        longint c;
        int d;
        s = 0;
        for (int j = 0; j < 16; j++) begin
            d = (r > j) ? (r - j) : (j - r);
            case (d)
                0: c = 20;
                1: c = -13;
                2: c = 6;
                3: c = -1;
                default: c = 0;
            endcase
            s += c * longint'(m_buf[j]);
        end
        return s;
    endfunction

    function automatic void push_rows(input int e0);
        exp_t   e;
        longint s;
        longint t;
        for (int r = 0; r < 16; r++) begin
            s = ref_sum(r);
            t = (s + 32768) >>> 16;
            if (t > 32767) t = 32767;
            if (t < -32768) t = -32768;
            e.full = s;
            e.rs   = t;
            e.tw   = (s >>> 16) & 64'hFFFF;
            e.at   = e0 + 1 + r;
            q.push_back(e);
        end
    endfunction

    // Check outputs for the current cycle, then drive the next inputs.
    task automatic tick(input logic en, input logic [31:0] x, input logic rst);
        logic exp_v;
        logic exp_busy;
        exp_t e;
        @(negedge clk);
        exp_v    = (q.size() > 0) && (q[0].at == cyc);
        exp_busy = (cyc >= m_e0) && (cyc <= m_e0 + 15);
        check_eq("rs_valid", longint'(rs_valid), longint'(exp_v));
        check_eq("tw_valid", longint'(tw_valid), longint'(exp_v));
        check_eq("rs_busy", longint'(rs_busy), longint'(exp_busy));
        check_eq("tw_busy", longint'(tw_busy), longint'(exp_busy));
        if (exp_v) begin
            e = q.pop_front();
            last_full = e.full;
            last_rs   = e.rs;
            last_tw   = e.tw;
        end
        check_eq("rs_b_full", longint'($signed(rs_b_full)), last_full);
        check_eq("tw_b_full", longint'($signed(tw_b_full)), last_full);
        check_eq("rs_b_out", longint'($signed(rs_b_out)), last_rs);
        check_eq("tw_b_out", longint'(tw_b_out), last_tw);

        reset = rst;
        in_en = en;
        x_in  = x;
        if (rst) begin
            q.delete();
            m_cnt = 0;
            m_e0 = -1000;
            last_full = 0;
            last_rs = 0;
            last_tw = 0;
            for (int i = 0; i < 16; i++) m_buf[i] = 0;
        end else if (en && !exp_busy) begin
            m_buf[m_cnt] = int'($signed(x));
            m_cnt++;
            if (m_cnt == 16) begin
                m_cnt = 0;
                m_e0 = cyc + 1;
                push_rows(m_e0);
            end
        end
    endtask

    logic [31:0] fr [16];

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 32'd0, 1'b0);
    endtask

    // Random in_en pulses; only used while the DUT is busy.
    task automatic busy_noise(input int n);
        for (int i = 0; i < n; i++) tick(1'($urandom_range(1, 0)), $urandom(), 1'b0);
    endtask

    // gap_mode 0: contiguous, 1: two idle cycles after each word, 2: random gaps.
    task automatic send_words(input int n, input int gap_mode);
        for (int k = 0; k < n; k++) begin
            tick(1'b1, fr[k], 1'b0);
            if (k != n - 1) begin
                if (gap_mode == 1) idle(2);
                else if (gap_mode == 2) idle(int'($urandom_range(2, 0)));
            end
        end
    endtask

    task automatic set_const(input logic [31:0] v);
        for (int k = 0; k < 16; k++) fr[k] = v;
    endtask

    task automatic set_single(input int idx, input logic [31:0] v);
        set_const(32'd0);
        fr[idx] = v;
    endtask

    task automatic set_random();
        for (int k = 0; k < 16; k++) begin
            case ($urandom_range(3, 0))
                0: fr[k] = $urandom();
                1: fr[k] = 32'($signed($urandom_range(262143, 0)) - 131072);
                2: fr[k] = ($urandom_range(1, 0) != 0) ? 32'h7FFFFFFF : 32'h80000000;
                default: fr[k] = 32'($urandom_range(65535, 0)) << 4;
            endcase
        end
    endtask

    initial begin
        idle(0);
        tick(1'b0, 32'd0, 1'b1);
        tick(1'b0, 32'd0, 1'b1);
        tick(1'b0, 32'd0, 1'b0);

        // All ones, contiguous, with in_en noise while busy.
        set_const(32'h00010000);
        send_words(16, 0);
        busy_noise(16);
        idle(4);

        // Impulse at x[5].
        set_single(5, 32'h00010000);
        send_words(16, 0);
        idle(20);

        // Rounding boundary at x[0] = 1/32.
        set_single(0, 32'h00000800);
        send_words(16, 0);
        idle(20);

        // Saturation at x[0] = most negative value.
        set_single(0, 32'h80000000);
        send_words(16, 0);
        idle(20);

        // Gapped ones, then a back-to-back impulse frame starting in the row-15 cycle.
        set_const(32'h00010000);
        send_words(16, 1);
        busy_noise(16);
        set_single(5, 32'h00010000);
        send_words(16, 0);
        idle(20);

        // Reset while row 7 is on the output, then a clean frame.
        set_random();
        send_words(16, 0);
        idle(8);
        tick(1'b0, 32'd0, 1'b1);
        idle(2);
        set_const(32'h00010000);
        send_words(16, 0);
        idle(20);

        // Reset mid-collection discards the partial frame.
        set_random();
        send_words(7, 0);
        tick(1'b0, 32'd0, 1'b1);
        set_single(3, 32'hFFFF0000);
        send_words(16, 2);
        idle(20);

        // Randomized frames with random gaps and random back-to-back chaining.
        for (int f = 0; f < 12; f++) begin
            set_random();
            send_words(16, 2);
            if ($urandom_range(1, 0) != 0) busy_noise(16);
            else idle(16 + int'($urandom_range(4, 0)));
        end

        idle(25);
        check_eq("drain", longint'(q.size()), 64'sd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
